// File: rtl/rs_dec.sv
`default_nettype none
// ============================================================================
//  Module      : rs_dec
//  Description : Streaming RS(204,188) decoder (t = 8, GF(256) poly 0x11D,
//                generator roots alpha^0..alpha^15). Each received block is
//                buffered while its syndromes accumulate. A key-equation
//                solver runs after the block ends, and Chien/Forney
//                correction runs while the next block streams in.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-high reset
//                CE         - input byte strobe
//                input_byte - received byte, x^203 coefficient first
//                Out_byte   - corrected data byte (registered, held)
//                CEO        - output strobe, one clock after each CE
//                Valid_out  - Out_byte carries a decoded data byte
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_dec (
    input  logic       clk,
    input  logic       reset,
    input  logic       CE,
    input  logic [7:0] input_byte,
    output logic [7:0] Out_byte,
    output logic       CEO,
    output logic       Valid_out
);

    localparam logic [7:0] C_LAST = 8'd203;
    localparam logic [7:0] C_NPAR = 8'd16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BM    = 2'd1,
        S_OMEGA = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // alpha^e by square-and-multiply; always called with constant exponents
    function automatic logic [7:0] gf_exp(input logic [7:0] e);
        logic [7:0] v;
        logic [7:0] base;
        v    = 8'h01;
        base = 8'h02;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) v = gf_mul(v, base);
            base = gf_mul(base, base);
        end
        return v;
    endfunction

    // a^254 = a^-1 (returns 0 for 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // ---------------------------------------------------------------- input side
    logic [7:0] r_cnt;
    logic       r_wbank;
    logic       r_start;
    logic [7:0] r_mem     [0:1][0:203];
    logic [7:0] r_syn_acc [0:15];
    logic [7:0] r_syn     [0:15];
    logic [7:0] w_syn_nxt [0:15];

    always_comb begin
        for (int i = 0; i < 16; i++)
            w_syn_nxt[i] = gf_mul(r_syn_acc[i], gf_exp(8'(i))) ^ input_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            r_wbank <= 1'b0;
            r_start <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_syn_acc[i] <= 8'h00;
                r_syn[i]     <= 8'h00;
            end
        end else begin
            r_start <= CE && (r_cnt == C_LAST);
            if (CE) begin
                if (r_cnt == C_LAST) begin
                    r_cnt   <= 8'd0;
                    r_wbank <= ~r_wbank;
                    for (int i = 0; i < 16; i++) begin
                        r_syn[i]     <= w_syn_nxt[i];
                        r_syn_acc[i] <= 8'h00;
                    end
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                    for (int i = 0; i < 16; i++)
                        r_syn_acc[i] <= w_syn_nxt[i];
                end
            end
        end
    end

    // Double buffer: the bank being read always holds the previous block.
    always_ff @(posedge clk) begin
        if (CE) r_mem[r_wbank][r_cnt] <= input_byte;
    end

    // ---------------------------------------------------------------- key equation
    state_t     r_state, w_state_nxt;
    logic [3:0] r_step;
    logic [4:0] r_len;
    logic [7:0] r_gamma;
    logic [7:0] r_lam     [0:8];
    logic [7:0] r_b       [0:8];
    logic [7:0] r_omg     [0:7];
    logic [7:0] w_lam_upd [0:8];
    logic [3:0] w_sidx    [0:8];
    logic [7:0] w_mac;

    // w_mac = sum_j lam_j * S_(step-j): the BM discrepancy in S_BM, and
    // coefficient 'step' of Omega = S*Lambda in S_OMEGA.
    always_comb begin
        w_mac = 8'h00;
        for (int j = 0; j < 9; j++) begin
            w_sidx[j] = r_step - 4'(j);
            if (4'(j) <= r_step) w_mac = w_mac ^ gf_mul(r_lam[j], r_syn[w_sidx[j]]);
        end
        // Inversionless update: Lambda <- gamma*Lambda + delta*x*B
        w_lam_upd[0] = gf_mul(r_gamma, r_lam[0]);
        for (int j = 1; j < 9; j++)
            w_lam_upd[j] = gf_mul(r_gamma, r_lam[j]) ^ gf_mul(w_mac, r_b[j-1]);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_start) w_state_nxt = S_BM;
            S_BM:    if (r_step == 4'd15) w_state_nxt = S_OMEGA;
            S_OMEGA: if (r_step == 4'd7) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------------------------------------------------------- Chien / Forney
    logic [7:0] r_ch_lam [0:8];
    logic [7:0] r_ch_omg [0:7];
    logic       r_have_blk;
    logic       w_out_slot;
    logic [7:0] w_lam_sum, w_lam_odd, w_omg_sum, w_rd_addr;

    assign w_out_slot = r_have_blk && (r_cnt >= C_NPAR);
    assign w_rd_addr  = (r_cnt >= C_NPAR) ? (r_cnt - C_NPAR) : 8'd0;

    always_comb begin
        w_lam_sum = 8'h00;
        w_omg_sum = 8'h00;
        for (int j = 0; j < 9; j++) w_lam_sum = w_lam_sum ^ r_ch_lam[j];
        for (int i = 0; i < 8; i++) w_omg_sum = w_omg_sum ^ r_ch_omg[i];
        // x*Lambda'(x) equals the odd part of Lambda in GF(2^m)
        w_lam_odd = r_ch_lam[1] ^ r_ch_lam[3] ^ r_ch_lam[5] ^ r_ch_lam[7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 9; j++) begin
                r_lam[j]    <= 8'h00;
                r_b[j]      <= 8'h00;
                r_ch_lam[j] <= 8'h00;
            end
            for (int i = 0; i < 8; i++) begin
                r_omg[i]    <= 8'h00;
                r_ch_omg[i] <= 8'h00;
            end
            r_gamma    <= 8'h00;
            r_len      <= 5'd0;
            r_step     <= 4'd0;
            r_have_blk <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start) begin
                        for (int j = 0; j < 9; j++) begin
                            r_lam[j] <= (j == 0) ? 8'h01 : 8'h00;
                            r_b[j]   <= (j == 0) ? 8'h01 : 8'h00;
                        end
                        r_gamma <= 8'h01;
                        r_len   <= 5'd0;
                        r_step  <= 4'd0;
                    end
                end
                S_BM: begin
                    for (int j = 0; j < 9; j++) r_lam[j] <= w_lam_upd[j];
                    if (w_mac != 8'h00 && {r_len, 1'b0} <= {2'b00, r_step}) begin
                        for (int j = 0; j < 9; j++) r_b[j] <= r_lam[j];
                        r_len   <= 5'(r_step) + 5'd1 - r_len;
                        r_gamma <= w_mac;
                    end else begin
                        r_b[0] <= 8'h00;
                        for (int j = 1; j < 9; j++) r_b[j] <= r_b[j-1];
                    end
                    r_step <= r_step + 4'd1;
                end
                S_OMEGA: begin
                    r_omg[r_step[2:0]] <= w_mac;
                    r_step             <= r_step + 4'd1;
                end
                S_LOAD: begin
                    // Pre-step to position 203: alpha^(-203*j) = alpha^(52*j)
                    for (int j = 0; j < 9; j++)
                        r_ch_lam[j] <= gf_mul(r_lam[j], gf_exp(8'((52 * j) % 255)));
                    for (int i = 0; i < 8; i++)
                        r_ch_omg[i] <= gf_mul(r_omg[i], gf_exp(8'((52 * i) % 255)));
                    r_have_blk <= 1'b1;
                    r_step     <= 4'd0;
                end
                default: ;
            endcase
            // Step to the next lower position after each evaluated output slot
            if (r_state != S_LOAD && CE && w_out_slot) begin
                for (int j = 0; j < 9; j++) r_ch_lam[j] <= gf_mul(r_ch_lam[j], gf_exp(8'(j)));
                for (int i = 0; i < 8; i++) r_ch_omg[i] <= gf_mul(r_ch_omg[i], gf_exp(8'(i)));
            end
        end
    end

    // ---------------------------------------------------------------- output stage
    // Evaluations are captured on the CE edge; the division and XOR complete
    // on the following edge, which is also the edge that raises CEO.
    logic       r_ce_d, r_pend_valid, r_pend_hit;
    logic [7:0] r_pend_byte, r_pend_omg, r_pend_odd;
    logic [7:0] w_err;

    assign w_err = r_pend_hit ? gf_mul(r_pend_omg, gf_inv(r_pend_odd)) : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ce_d       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_hit   <= 1'b0;
            r_pend_byte  <= 8'h00;
            r_pend_omg   <= 8'h00;
            r_pend_odd   <= 8'h00;
            CEO          <= 1'b0;
            Valid_out    <= 1'b0;
            Out_byte     <= 8'h00;
        end else begin
            r_ce_d <= CE;
            CEO    <= r_ce_d;
            if (CE) begin
                r_pend_valid <= w_out_slot;
                r_pend_hit   <= (w_lam_sum == 8'h00);
                r_pend_byte  <= r_mem[~r_wbank][w_rd_addr];
                r_pend_omg   <= w_omg_sum;
                r_pend_odd   <= w_lam_odd;
            end
            if (r_ce_d) begin
                Valid_out <= r_pend_valid;
                Out_byte  <= r_pend_valid ? (r_pend_byte ^ w_err) : 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_dec
//  Description : Self-checking bench for rs_dec. A table of block records
//                (error count, position-0 forcing, all-zero codeword,
//                expected correctability) is encoded and streamed. Original
//                data bytes go into a scoreboard queue and are compared when
//                the decoder raises Valid_out. Hand sequences cover the
//                CE-idle hold and a mid-block reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_dec;

    logic       clk = 1'b0;
    logic       reset;
    logic       CE;
    logic [7:0] input_byte;
    logic [7:0] Out_byte;
    logic       CEO;
    logic       Valid_out;

    always #5 clk = ~clk;

    rs_dec dut (
        .clk        (clk),
        .reset      (reset),
        .CE         (CE),
        .input_byte (input_byte),
        .Out_byte   (Out_byte),
        .CEO        (CEO),
        .Valid_out  (Valid_out)
    );

    typedef struct { logic [7:0] val; bit chk; } sb_t;
    typedef struct { int n_err; bit pos0; bit zero_cw; bit expect_ok; } vec_t;

    sb_t        sb_q[$];
    vec_t       tbl [0:19];
    logic [7:0] g   [0:16];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         slot     = 0;
    int         blocks   = 0;

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic vec_t mk(input int n, input bit p0, input bit z, input bit ok);
        vec_t v;
        v.n_err = n; v.pos0 = p0; v.zero_cw = z; v.expect_ok = ok;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (slot %0d, block %0d)", name, act, req, slot, blocks);
        end
    endtask

    // One CE strobe with the CEO/Valid_out/Out_byte protocol checked around it.
    task automatic send_byte(input logic [7:0] b);
        sb_t        e;
        logic [7:0] held_byte;
        logic       held_valid;
        bit         exp_valid;
        @(negedge clk);
        CE = 1'b1;
        input_byte = b;
        @(negedge clk);
        CE = 1'b0;
        check("ceo_early", int'(CEO), 0);
        @(negedge clk);
        exp_valid = (blocks >= 1) && (slot >= 16);
        check("ceo_pulse", int'(CEO), 1);
        check("valid_out", int'(Valid_out), int'(exp_valid));
        if (exp_valid) begin
            check("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) check("data", int'(Out_byte), int'(e.val));
            end
        end
        held_byte  = Out_byte;
        held_valid = Valid_out;
        @(negedge clk);
        check("ceo_width", int'(CEO), 0);
        check("out_hold", int'(Out_byte), int'(held_byte));
        check("valid_hold", int'(Valid_out), int'(held_valid));
        repeat (4) @(negedge clk);
        slot++;
        if (slot == 204) begin
            slot = 0;
            blocks++;
        end
    endtask

    task automatic send_block(input vec_t v, input int nbytes);
        logic [7:0] cw  [0:203];
        logic [7:0] par [0:15];
        logic [7:0] fb;
        int         pos [0:15];
        int         np;
        int         p;
        bit         dup;
        for (int j = 0; j < 188; j++)
            cw[j] = v.zero_cw ? 8'h00 : 8'($urandom_range(0, 255));
        for (int k = 0; k < 16; k++) par[k] = 8'h00;
        for (int j = 0; j < 188; j++) begin
            fb = cw[j] ^ par[15];
            for (int k = 15; k > 0; k--) par[k] = par[k-1] ^ tb_gmul(fb, g[k]);
            par[0] = tb_gmul(fb, g[0]);
        end
        for (int k = 0; k < 16; k++) cw[188 + k] = par[15 - k];
        for (int j = 0; j < 188; j++) sb_q.push_back('{val: cw[j], chk: v.expect_ok});
        np = 0;
        while (np < v.n_err) begin
            if (np == 0 && v.pos0)  p = 0;
            else if (np == 1)       p = 188 + int'($urandom_range(0, 15));
            else                    p = int'($urandom_range(0, 203));
            dup = 1'b0;
            for (int q = 0; q < np; q++) if (pos[q] == p) dup = 1'b1;
            if (!dup) begin
                pos[np] = p;
                np++;
                cw[p] = cw[p] ^ (v.zero_cw ? 8'hFF : 8'($urandom_range(1, 255)));
            end
        end
        for (int j = 0; j < nbytes; j++) send_byte(cw[j]);
    endtask

    initial begin
        logic [7:0] a;
        reset = 1'b1;
        CE = 1'b0;
        input_byte = 8'h00;

        // g(x) = prod (x + alpha^i), i = 0..15
        g[0] = 8'h01;
        for (int k = 1; k < 17; k++) g[k] = 8'h00;
        a = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int k = 16; k > 0; k--) g[k] = g[k-1] ^ tb_gmul(g[k], a);
            g[0] = tb_gmul(g[0], a);
            a = tb_gmul(a, 8'h02);
        end

        tbl[0]  = mk(0,  1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(0,  1'b0, 1'b0, 1'b1);
        tbl[2]  = mk(1,  1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(2,  1'b0, 1'b0, 1'b1);
        tbl[4]  = mk(3,  1'b1, 1'b0, 1'b1);
        tbl[5]  = mk(4,  1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(5,  1'b0, 1'b0, 1'b1);
        tbl[7]  = mk(6,  1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(7,  1'b0, 1'b0, 1'b1);
        tbl[9]  = mk(8,  1'b1, 1'b0, 1'b1);
        tbl[10] = mk(8,  1'b0, 1'b0, 1'b1);
        tbl[11] = mk(1,  1'b1, 1'b1, 1'b1);
        tbl[12] = mk(12, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(0,  1'b0, 1'b0, 1'b1);
        tbl[14] = mk(8,  1'b0, 1'b0, 1'b1);
        tbl[15] = mk(3,  1'b0, 1'b0, 1'b1);
        tbl[16] = mk(10, 1'b1, 1'b0, 1'b0);
        tbl[17] = mk(1,  1'b0, 1'b0, 1'b1);
        tbl[18] = mk(5,  1'b1, 1'b0, 1'b1);
        tbl[19] = mk(0,  1'b0, 1'b0, 1'b1);

        repeat (6) @(negedge clk);
        check("rst_out",   int'(Out_byte), 0);
        check("rst_ceo",   int'(CEO), 0);
        check("rst_valid", int'(Valid_out), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ceo", int'(CEO), 0);

        for (int i = 0; i < 20; i++) begin
            send_block(tbl[i], 204);
            if (i == 14) begin
                // CE idle: state must hold and no CEO may appear
                repeat (40) begin
                    @(negedge clk);
                    check("idle_ceo", int'(CEO), 0);
                end
            end
        end

        // Reset in the middle of a block; pending outputs are discarded
        send_block(mk(0, 1'b0, 1'b0, 1'b1), 100);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_out",   int'(Out_byte), 0);
            check("mid_rst_ceo",   int'(CEO), 0);
            check("mid_rst_valid", int'(Valid_out), 0);
        end
        reset = 1'b0;
        sb_q.delete();
        slot = 0;
        blocks = 0;
        send_block(mk(2, 1'b1, 1'b0, 1'b1), 204);
        send_block(mk(4, 1'b0, 1'b0, 1'b1), 204);
        send_block(mk(0, 1'b0, 1'b0, 1'b1), 204);

        // The last block's data is still waiting for the next block period
        check("sb_pending", sb_q.size(), 188);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
